// File: rtl/opc5ls_mem_arbiter.sv
// opc5ls_mem_arbiter: shares one synchronous single-port memory between two req/ack ports
//
// Port 0 (CPU side) has priority. Port 1 (DMA/video side) is guaranteed progress by a
// starvation counter. A 4-state sequencer (IDLE -> ACCESS -> [WAIT] -> ACK) drives the memory.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m0_req/m0_rnw/m0_addr/m0_wdata  port 0 request; fields held stable until m0_ack
//   m0_ack, m0_rdata                port 0 one-cycle completion pulse and read data
//   m1_*                            same for port 1
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe, write enable, address, write data
//   mem_rdata                       memory read data, valid RDLAT cycles after mem_en
//   owner                           port currently or most recently granted
//   busy                            high whenever the sequencer is not in IDLE
module opc5ls_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RDLAT      = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_rnw,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_rnw,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] ACK    = 2'd3;

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [3:0]    starve_cnt;
    logic [DW-1:0] rdata_q;
    logic          grant1;
    logic          sel_rnw;

    // Port 1 wins when port 0 is absent or port 0 has used up its consecutive-grant allowance.
    assign grant1  = m1_req && (!m0_req || starve_cnt == 4'(STARVE_MAX));
    // After the grant only the owner's request fields matter.
    assign sel_rnw = owner ? m1_rnw : m0_rnw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
            rdata_q    <= '0;
            cnt        <= 3'd0;
        end else begin
            case (state)
                IDLE: if (m0_req || m1_req) begin
                    owner      <= grant1;
                    state      <= ACCESS;
                    starve_cnt <= grant1 ? 4'd0 :
                                  (m1_req && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
                end
                ACCESS: begin
                    state <= sel_rnw ? WAIT : ACK;
                    cnt   <= 3'(RDLAT - 1);
                end
                WAIT: if (cnt == 3'd0) begin
                    rdata_q <= mem_rdata;
                    state   <= ACK;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = state != IDLE;
    assign mem_en    = state == ACCESS;
    assign mem_we    = mem_en && !sel_rnw;
    // Address and data are forced to zero outside ACCESS so the bus is quiet when idle.
    assign mem_addr  = mem_en ? (owner ? m1_addr : m0_addr) : '0;
    assign mem_wdata = mem_en ? (owner ? m1_wdata : m0_wdata) : '0;
    assign m0_ack    = state == ACK && !owner;
    assign m1_ack    = state == ACK && owner;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
endmodule

// File: tb/tb_opc5ls_mem_arbiter.sv
// tb_opc5ls_mem_arbiter: directed checks of the two-port memory arbiter at RDLAT=1 and RDLAT=3
module tb_opc5ls_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m0_req = 0, m0_rnw = 0, m1_req = 0, m1_rnw = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic a_m0_ack, a_m1_ack, a_en, a_we, a_owner, a_busy;
    logic [15:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata, a_rdata;
    logic b_m0_ack, b_m1_ack, b_en, b_we, b_owner, b_busy;
    logic [15:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata, b_rdata;
    logic [15:0] mem_a [0:4095];
    logic [15:0] mem_b [0:4095];
    logic [15:0] b_p0, b_p1, b_p2;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    opc5ls_mem_arbiter #(.RDLAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_rdata(a_rdata), .owner(a_owner), .busy(a_busy)
    );

    opc5ls_mem_arbiter #(.RDLAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_rdata(b_rdata), .owner(b_owner), .busy(b_busy)
    );

    // Memory models: one-cycle read for dut_a, three-stage read pipe for dut_b.
    always @(posedge clk) begin
        if (a_en && a_we) mem_a[a_addr[11:0]] <= a_wdata;
        if (a_en && !a_we) a_rdata <= mem_a[a_addr[11:0]];
        if (b_en && b_we) mem_b[b_addr[11:0]] <= b_wdata;
        b_p0 <= (b_en && !b_we) ? mem_b[b_addr[11:0]] : 16'h0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_rdata = b_p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; m0_req = 0; m1_req = 0; m0_addr = 16'h0abc; m0_wdata = 16'h0def;
        step(); step();
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        vectors++; if (a_owner !== 1'b0) begin miscompares++; $display("FAIL reset_owner: got %b want 0", a_owner); end
        vectors++; if ({a_m0_ack, a_m1_ack, a_en, a_we} !== 4'b0) begin miscompares++; $display("FAIL reset_strobes: got %b want 0000", {a_m0_ack, a_m1_ack, a_en, a_we}); end
        vectors++; if ({a_addr, a_wdata} !== 32'h0) begin miscompares++; $display("FAIL reset_bus: got %h want 0", {a_addr, a_wdata}); end
        vectors++; if (a_m0_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", a_m0_rdata); end
        vectors++; if ({b_busy, b_owner, b_m0_ack, b_m1_ack, b_en} !== 5'b0) begin miscompares++; $display("FAIL reset_b: got %b want 00000", {b_busy, b_owner, b_m0_ack, b_m1_ack, b_en}); end
        reset = 0;
    endtask

    task automatic test_write_read();
        m0_req = 1; m0_rnw = 0; m0_addr = 16'h0100; m0_wdata = 16'hBEEF;
        step();
        vectors++; if ({a_en, a_we} !== 2'b11) begin miscompares++; $display("FAIL t1_wr_en_we: got %b want 11", {a_en, a_we}); end
        vectors++; if (a_addr !== 16'h0100 || a_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL t1_wr_bus: got %h/%h want 0100/beef", a_addr, a_wdata); end
        vectors++; if (a_m0_ack !== 1'b0) begin miscompares++; $display("FAIL t1_early_ack: got %b want 0", a_m0_ack); end
        step();
        vectors++; if ({a_m0_ack, a_m1_ack} !== 2'b10) begin miscompares++; $display("FAIL t1_wr_ack: got %b want 10", {a_m0_ack, a_m1_ack}); end
        m0_rnw = 1;
        step();
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL t1_idle_busy: got %b want 0", a_busy); end
        step();
        vectors++; if ({a_en, a_we} !== 2'b10) begin miscompares++; $display("FAIL t1_rd_en_we: got %b want 10", {a_en, a_we}); end
        step();
        vectors++; if ({a_en, a_m0_ack} !== 2'b00) begin miscompares++; $display("FAIL t1_wait: got %b want 00", {a_en, a_m0_ack}); end
        step();
        vectors++; if (a_m0_ack !== 1'b1) begin miscompares++; $display("FAIL t1_rd_ack: got %b want 1", a_m0_ack); end
        vectors++; if (a_m0_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL t1_rd_data: got %h want beef", a_m0_rdata); end
        m0_req = 0;
        step();
        vectors++; if ({a_m0_ack, a_busy} !== 2'b00) begin miscompares++; $display("FAIL t1_after: got %b want 00", {a_m0_ack, a_busy}); end
    endtask

    task automatic test_long_read();
        int ack_cyc = -1;
        int en_cnt = 0;
        logic [15:0] rd = 16'h0;
        m1_req = 1; m1_rnw = 0; m1_addr = 16'h0200; m1_wdata = 16'h1234;
        step(); step();
        vectors++; if (b_m1_ack !== 1'b1) begin miscompares++; $display("FAIL t2_wr_ack: got %b want 1", b_m1_ack); end
        m1_rnw = 1;
        step();
        for (int k = 1; k <= 7; k++) begin
            step();
            if (b_en) en_cnt++;
            if (b_m1_ack && ack_cyc < 0) begin ack_cyc = k; rd = b_m1_rdata; m1_req = 0; end
        end
        vectors++; if (ack_cyc != 5) begin miscompares++; $display("FAIL t2_ack_cycle: got %0d want 5", ack_cyc); end
        vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL t2_rdata: got %h want 1234", rd); end
        vectors++; if (en_cnt != 1) begin miscompares++; $display("FAIL t2_en_cycles: got %0d want 1", en_cnt); end
    endtask

    task automatic test_starvation();
        int got [8];
        int exp_order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int n = 0;
        int overlap = 0;
        m0_req = 1; m0_rnw = 0; m0_addr = 16'h0300; m0_wdata = 16'h3333;
        m1_req = 1; m1_rnw = 0; m1_addr = 16'h0310; m1_wdata = 16'h4444;
        for (int k = 0; k < 40 && n < 8; k++) begin
            step();
            if (a_m0_ack && a_m1_ack) overlap++;
            if (a_m0_ack || a_m1_ack) begin got[n] = int'(a_m1_ack); n++; end
        end
        m0_req = 0; m1_req = 0;
        vectors++; if (n != 8) begin miscompares++; $display("FAIL t3_grant_count: got %0d want 8", n); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (got[i] != exp_order[i]) begin miscompares++; $display("FAIL t3_order[%0d]: got %0d want %0d", i, got[i], exp_order[i]); end
        end
        vectors++; if (overlap != 0) begin miscompares++; $display("FAIL t3_ack_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int overlap = 0;
        int first = -1, second = -1, c1 = -1, c2 = -1;
        m0_req = 1; m0_rnw = 0; m0_addr = 16'h0320; m0_wdata = 16'h5555;
        m1_req = 1; m1_rnw = 0; m1_addr = 16'h0330; m1_wdata = 16'h6666;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (a_m0_ack && a_m1_ack) overlap++;
            if (a_m0_ack || a_m1_ack) begin
                if (n == 0) begin first = int'(a_m1_ack); c1 = k; end
                else if (n == 1) begin second = int'(a_m1_ack); c2 = k; end
                n++;
                if (a_m0_ack) m0_req = 0;
                if (a_m1_ack) m1_req = 0;
            end
        end
        vectors++; if (first != 0 || c1 != 2) begin miscompares++; $display("FAIL t4_first: got port %0d cyc %0d want port 0 cyc 2", first, c1); end
        vectors++; if (second != 1 || c2 != 5) begin miscompares++; $display("FAIL t4_second: got port %0d cyc %0d want port 1 cyc 5", second, c2); end
        vectors++; if (n != 2 || overlap != 0) begin miscompares++; $display("FAIL t4_acks: got n=%0d overlap=%0d want n=2 overlap=0", n, overlap); end
    endtask

    task automatic test_reset_mid_read();
        int ack_cyc = -1;
        logic [15:0] rd = 16'h0;
        m1_req = 1; m1_rnw = 1; m1_addr = 16'h0200;
        step();
        vectors++; if (b_en !== 1'b1) begin miscompares++; $display("FAIL t5_access: got %b want 1", b_en); end
        step();
        vectors++; if ({b_busy, b_en} !== 2'b10) begin miscompares++; $display("FAIL t5_wait: got %b want 10", {b_busy, b_en}); end
        reset = 1;
        step();
        vectors++; if ({b_busy, b_en, b_m0_ack, b_m1_ack} !== 4'b0) begin miscompares++; $display("FAIL t5_b_aborted: got %b want 0000", {b_busy, b_en, b_m0_ack, b_m1_ack}); end
        vectors++; if ({a_busy, a_m0_ack, a_m1_ack} !== 3'b0) begin miscompares++; $display("FAIL t5_a_aborted: got %b want 000", {a_busy, a_m0_ack, a_m1_ack}); end
        reset = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (b_m1_ack && ack_cyc < 0) begin ack_cyc = k; rd = b_m1_rdata; m1_req = 0; end
        end
        vectors++; if (ack_cyc != 5) begin miscompares++; $display("FAIL t5_resume_cycle: got %0d want 5", ack_cyc); end
        vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL t5_resume_data: got %h want 1234", rd); end
    endtask

    task automatic test_owner_mux();
        m0_req = 0; m0_addr = 16'h0111; m0_wdata = 16'h2222;
        m1_req = 1; m1_rnw = 0; m1_addr = 16'h0400; m1_wdata = 16'h5A5A;
        step();
        m0_addr = 16'h0999; m0_wdata = 16'h7777;
        #1;
        vectors++; if (a_addr !== 16'h0400 || a_wdata !== 16'h5A5A) begin miscompares++; $display("FAIL t6_bus: got %h/%h want 0400/5a5a", a_addr, a_wdata); end
        vectors++; if ({a_owner, a_we} !== 2'b11) begin miscompares++; $display("FAIL t6_owner_we: got %b want 11", {a_owner, a_we}); end
        step();
        vectors++; if ({a_m0_ack, a_m1_ack} !== 2'b01) begin miscompares++; $display("FAIL t6_ack: got %b want 01", {a_m0_ack, a_m1_ack}); end
        m1_req = 0;
        step();
        vectors++; if ({a_owner, a_busy} !== 2'b10) begin miscompares++; $display("FAIL t6_owner_hold: got %b want 10", {a_owner, a_busy}); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset();
        test_long_read();
        test_reset();
        test_starvation();
        test_reset();
        test_simultaneous();
        test_reset();
        test_reset_mid_read();
        test_reset();
        test_owner_mux();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
